// File: rtl/cargador_pkg.sv
// rtl/cargador_pkg.sv - shared types and default widths for the operand loader and the ALU
package cargador_pkg;

   localparam int ANCHO_DATO_DEF = 8;
   localparam int ANCHO_OP_DEF   = 4;

   typedef enum logic [1:0] {
      CARGA_A,
      CARGA_B,
      CARGA_OP,
      EMITIR
   } estado_carga_t;

   // Opcode encoding understood by the 8-bit ALU
   typedef enum logic [ANCHO_OP_DEF-1:0] {
      OP_SUMA  = 4'h0,
      OP_RESTA = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_NOT   = 4'h5,
      OP_SHL   = 4'h6,
      OP_SHR   = 4'h7
   } codigo_alu_t;

   // Even parity: the parity bit plus data bits hold an even number of ones
   function automatic logic paridad_par_ok(input logic [ANCHO_DATO_DEF:0] palabra);
      return ~(^palabra);
   endfunction

endpackage

// File: rtl/cargador_operandos.sv
// rtl/cargador_operandos.sv - assembles operand A, operand B and opcode from a byte stream for the ALU
// Optional parity checking on each byte is enabled with CARGADOR_PARIDAD_EN.
module cargador_operandos
   import cargador_pkg::*;
#(
   parameter int ANCHO_DATO = ANCHO_DATO_DEF,
   parameter int ANCHO_OP   = ANCHO_OP_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef CARGADOR_PARIDAD_EN
   input  logic [ANCHO_DATO:0]   dato_in,
`else
   input  logic [ANCHO_DATO-1:0] dato_in,
`endif
   input  logic                  dato_valido,
   output logic                  dato_listo,
   output logic [ANCHO_DATO-1:0] operando_a,
   output logic [ANCHO_DATO-1:0] operando_b,
   output logic [ANCHO_OP-1:0]   codigo_op,
   output logic                  inicio,
   input  logic                  alu_ack,
   output logic                  ocupado
`ifdef CARGADOR_PARIDAD_EN
   ,
   output logic                  error_paridad
`endif
);

   estado_carga_t estado;
   logic          transferencia;
   logic          paridad_ok;

   // Handshake outputs depend on state only, so no path from dato_valido or alu_ack
   assign dato_listo    = (estado != EMITIR);
   assign inicio        = (estado == EMITIR);
   assign ocupado       = (estado != CARGA_A);
   assign transferencia = dato_valido && dato_listo;

`ifdef CARGADOR_PARIDAD_EN
   assign paridad_ok = ~(^dato_in);
`else
   assign paridad_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         estado     <= CARGA_A;
         operando_a <= '0;
         operando_b <= '0;
         codigo_op  <= '0;
`ifdef CARGADOR_PARIDAD_EN
         error_paridad <= 1'b0;
`endif
      end else begin
`ifdef CARGADOR_PARIDAD_EN
         error_paridad <= transferencia && !paridad_ok;
`endif
         if (transferencia && !paridad_ok) begin
            // A corrupted byte throws away whatever part of the triple was loaded
            estado <= CARGA_A;
         end else begin
            case (estado)
               CARGA_A: begin
                  if (transferencia) begin
                     operando_a <= dato_in[ANCHO_DATO-1:0];
                     estado     <= CARGA_B;
                  end
               end
               CARGA_B: begin
                  if (transferencia) begin
                     operando_b <= dato_in[ANCHO_DATO-1:0];
                     estado     <= CARGA_OP;
                  end
               end
               CARGA_OP: begin
                  if (transferencia) begin
                     codigo_op <= dato_in[ANCHO_OP-1:0];
                     estado    <= EMITIR;
                  end
               end
               EMITIR: begin
                  if (alu_ack) begin
                     estado <= CARGA_A;
                  end
               end
               default: estado <= CARGA_A;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cargador_operandos.sv
// tb/tb_cargador_operandos.sv - self-checking bench for cargador_operandos
module tb_cargador_operandos;

`ifdef CARGADOR_PARIDAD_EN
   localparam int ANCHO_IN = 9;
`else
   localparam int ANCHO_IN = 8;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [ANCHO_IN-1:0] dato_in = '0;
   logic                dato_valido = 1'b0;
   logic                dato_listo;
   logic [7:0]          operando_a;
   logic [7:0]          operando_b;
   logic [3:0]          codigo_op;
   logic                inicio;
   logic                alu_ack = 1'b0;
   logic                ocupado;
`ifdef CARGADOR_PARIDAD_EN
   logic                error_paridad;
`endif

   int checks = 0;
   int failures = 0;

   cargador_operandos #(.ANCHO_DATO(8), .ANCHO_OP(4)) dut (
      .clk(clk),
      .rst(rst),
      .dato_in(dato_in),
      .dato_valido(dato_valido),
      .dato_listo(dato_listo),
      .operando_a(operando_a),
      .operando_b(operando_b),
      .codigo_op(codigo_op),
      .inicio(inicio),
      .alu_ack(alu_ack),
      .ocupado(ocupado)
`ifdef CARGADOR_PARIDAD_EN
      ,
      .error_paridad(error_paridad)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      int         gap;
      logic [7:0] ea;
      logic [7:0] eb;
      logic [3:0] eop;
   } vec_t;

   vec_t tabla [4];

   task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nombre, act, exp);
      end
   endtask

   function automatic logic [ANCHO_IN-1:0] con_paridad(input logic [7:0] b);
`ifdef CARGADOR_PARIDAD_EN
      return {^b, b};
`else
      return b;
`endif
   endfunction

   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   // Offers one byte, waits (bounded) for acceptance, then idles for gap cycles
   task automatic enviar(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      dato_in = con_paridad(b);
      dato_valido = 1'b1;
      while (!dato_listo && n < 20) begin
         ciclo();
         n++;
      end
      if (n == 20) chk("timeout_dato_listo", 0, 1);
      ciclo();
      dato_valido = 1'b0;
      dato_in = '0;
      repeat (gap) ciclo();
   endtask

   task automatic reconocer();
      alu_ack = 1'b1;
      ciclo();
      alu_ack = 1'b0;
   endtask

   initial begin
      tabla[0] = '{a: 8'h3C, b: 8'h05, op: 8'h02, gap: 0, ea: 8'h3C, eb: 8'h05, eop: 4'h2};
      tabla[1] = '{a: 8'hF0, b: 8'h0F, op: 8'hF7, gap: 0, ea: 8'hF0, eb: 8'h0F, eop: 4'h7};
      tabla[2] = '{a: 8'h12, b: 8'h34, op: 8'h0A, gap: 3, ea: 8'h12, eb: 8'h34, eop: 4'hA};
      tabla[3] = '{a: 8'h00, b: 8'hFF, op: 8'h1F, gap: 1, ea: 8'h00, eb: 8'hFF, eop: 4'hF};

      rst = 1'b1;
      ciclo();
      ciclo();
      rst = 1'b0;
      chk("rst_dato_listo", dato_listo, 1);
      chk("rst_inicio", inicio, 0);
      chk("rst_ocupado", ocupado, 0);
      chk("rst_operando_a", operando_a, 0);
      chk("rst_operando_b", operando_b, 0);
      chk("rst_codigo_op", codigo_op, 0);
`ifdef CARGADOR_PARIDAD_EN
      chk("rst_error_paridad", error_paridad, 0);
`endif

      for (int i = 0; i < 4; i++) begin
         enviar(tabla[i].a, tabla[i].gap);
         chk($sformatf("v%0d_ocupado_a", i), ocupado, 1);
         chk($sformatf("v%0d_inicio_a", i), inicio, 0);
         enviar(tabla[i].b, tabla[i].gap);
         chk($sformatf("v%0d_ocupado_b", i), ocupado, 1);
         chk($sformatf("v%0d_inicio_b", i), inicio, 0);
         dato_in = con_paridad(tabla[i].op);
         dato_valido = 1'b1;
         ciclo();
         dato_valido = 1'b0;
         chk($sformatf("v%0d_inicio", i), inicio, 1);
         chk($sformatf("v%0d_dato_listo", i), dato_listo, 0);
         chk($sformatf("v%0d_operando_a", i), operando_a, tabla[i].ea);
         chk($sformatf("v%0d_operando_b", i), operando_b, tabla[i].eb);
         chk($sformatf("v%0d_codigo_op", i), codigo_op, tabla[i].eop);
         if (i == 0) begin
            dato_in = con_paridad(8'hFF);
            dato_valido = 1'b1;
            for (int k = 0; k < 10; k++) begin
               ciclo();
               chk("bp_dato_listo", dato_listo, 0);
               chk("bp_inicio", inicio, 1);
            end
            dato_valido = 1'b0;
            chk("bp_operando_a", operando_a, 8'h3C);
            chk("bp_operando_b", operando_b, 8'h05);
            chk("bp_codigo_op", codigo_op, 4'h2);
         end
         chk($sformatf("v%0d_ocupado_emitir", i), ocupado, 1);
         reconocer();
         chk($sformatf("v%0d_inicio_tras_ack", i), inicio, 0);
         chk($sformatf("v%0d_listo_tras_ack", i), dato_listo, 1);
         chk($sformatf("v%0d_ocupado_tras_ack", i), ocupado, 0);
         chk($sformatf("v%0d_a_retenido", i), operando_a, tabla[i].ea);
         chk($sformatf("v%0d_op_retenido", i), codigo_op, tabla[i].eop);
      end

      // Acks outside EMITIR must not move the FSM
      reconocer();
      chk("ack_idle_ocupado", ocupado, 0);
      enviar(8'h55, 0);
      reconocer();
      chk("ack_carga_b_ocupado", ocupado, 1);
      chk("ack_carga_b_inicio", inicio, 0);
      enviar(8'h66, 0);
      enviar(8'h03, 0);
      chk("ack_seq_inicio", inicio, 1);
      chk("ack_seq_operando_a", operando_a, 8'h55);
      chk("ack_seq_operando_b", operando_b, 8'h66);
      reconocer();

      // Reset in the middle of a load discards the partial triple
      enviar(8'hAA, 0);
      enviar(8'hBB, 0);
      rst = 1'b1;
      ciclo();
      rst = 1'b0;
      chk("mrst_operando_a", operando_a, 0);
      chk("mrst_operando_b", operando_b, 0);
      chk("mrst_codigo_op", codigo_op, 0);
      chk("mrst_inicio", inicio, 0);
      chk("mrst_ocupado", ocupado, 0);
      chk("mrst_dato_listo", dato_listo, 1);
      enviar(8'h11, 0);
      enviar(8'h22, 0);
      enviar(8'h33, 0);
      chk("mrst_nuevo_inicio", inicio, 1);
      chk("mrst_nuevo_a", operando_a, 8'h11);
      chk("mrst_nuevo_b", operando_b, 8'h22);
      chk("mrst_nuevo_op", codigo_op, 4'h3);
      reconocer();

`ifdef CARGADOR_PARIDAD_EN
      enviar(8'h10, 0);
      dato_in = {1'b0, 8'h01};
      dato_valido = 1'b1;
      ciclo();
      dato_valido = 1'b0;
      chk("par_error_pulso", error_paridad, 1);
      chk("par_ocupado", ocupado, 0);
      chk("par_dato_listo", dato_listo, 1);
      chk("par_inicio", inicio, 0);
      ciclo();
      chk("par_error_fin", error_paridad, 0);
      chk("par_inicio_sigue", inicio, 0);
      chk("par_ocupado_sigue", ocupado, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cargador_operandos.md
Name: cargador_operandos

Overview:
- Input-side counterpart of the ALU output register. It accepts a byte stream from the host or bus side and assembles operand A, operand B and the opcode.
- It presents the assembled triple to the 8-bit ALU with a valid/ack handshake.
- It sits between the host byte interface and the ALU operand inputs. The result path back to the host stays with the existing output register.

Parameters:
- ANCHO_DATO, 8, width of each operand and of the incoming byte bus.
- ANCHO_OP, 4, opcode width; the opcode is taken from dato_in[ANCHO_OP-1:0] of the third byte.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- dato_in  input  ANCHO_DATO  incoming byte.
- dato_valido  input  1  dato_in is valid this cycle.
- dato_listo  output  1  block can accept a byte; a byte transfers when dato_valido and dato_listo are both 1 on the same edge.
- operando_a  output  ANCHO_DATO  registered operand A.
- operando_b  output  ANCHO_DATO  registered operand B.
- codigo_op  output  ANCHO_OP  registered opcode.
- inicio  output  1  the operand triple is valid toward the ALU.
- alu_ack  input  1  ALU has consumed the triple.
- ocupado  output  1  high while a transaction is partially loaded or pending.
- error_paridad  output  1  only present with PARIDAD_EN; see Optional Feature.

Behaviour:
- Reset (rst=1 at an edge):
  - state=CARGA_A; operando_a, operando_b, codigo_op = 0; inicio=0; ocupado=0; error_paridad=0.
  - Reset overrides all other events, including a mid-transaction reset. Any partial load is discarded.
- FSM states: CARGA_A, CARGA_B, CARGA_OP, EMITIR.
- CARGA_A: dato_listo=1. On transfer: operando_a<=dato_in, go to CARGA_B.
- CARGA_B: dato_listo=1. On transfer: operando_b<=dato_in, go to CARGA_OP.
- CARGA_OP: dato_listo=1. On transfer: codigo_op<=dato_in[ANCHO_OP-1:0] (upper bits ignored), go to EMITIR.
- EMITIR: dato_listo=0; inicio=1.
  - Operand and opcode registers are held stable while inicio=1.
  - On alu_ack=1: go to CARGA_A; inicio drops on the next cycle.
  - Operands keep their last values after the ack (they are not cleared).
- dato_listo and inicio are decoded combinationally from state only; no combinational path from dato_valido or alu_ack.
- Latency: inicio rises on the cycle after the third byte transfers. Minimum transaction is 4 cycles (3 bytes + 1 cycle with ack).
- alu_ack outside EMITIR is ignored. A dato_valido while dato_listo=0 is ignored and not buffered; the producer must hold it.
- ocupado = 1 in CARGA_B, CARGA_OP and EMITIR; 0 in CARGA_A.
- There is no timeout; the block waits indefinitely for bytes or ack.

Optional Feature:
- Macro: CARGADOR_PARIDAD_EN.
- With the macro:
  - dato_in is widened by 1 bit; the MSB is an even-parity bit over the lower ANCHO_DATO bits.
  - A transfer with bad parity does not advance the FSM. The FSM returns to CARGA_A and discards the partial triple.
  - error_paridad pulses 1 for one cycle.
- Without the macro: the port is absent and dato_in is exactly ANCHO_DATO wide.

Decomposition:
- Package cargador_pkg holds:
  - estado_carga_t enum (CARGA_A, CARGA_B, CARGA_OP, EMITIR);
  - default width constants ANCHO_DATO_DEF=8 and ANCHO_OP_DEF=4.
- The opcode encoding typedef is shared with the ALU and lives in the same package.
- Sub-module: none required. With the option enabled, a small combinational verificador_paridad is natural.

Test Plan:
- Basic load: send 0x3C, 0x05, 0x02 with dato_valido held → inicio=1 one cycle after the 3rd byte with operando_a=0x3C, operando_b=0x05, codigo_op=0x2; assert alu_ack → inicio=0 next cycle and state=CARGA_A.
- Backpressure: keep alu_ack=0 for 10 cycles while driving dato_valido=1 with 0xFF → dato_listo=0, operands unchanged, inicio stays 1.
- Gapped source: bytes spaced by 3 idle cycles each → same triple captured and ocupado=1 from first byte to ack.
- Mid-transaction reset: load 0xAA, 0xBB, then rst=1 → all outputs 0 and state=CARGA_A; the next 3 bytes form a fresh triple.
- Opcode truncation: third byte 0xF7 with ANCHO_OP=4 → codigo_op=0x7.
- (CARGADOR_PARIDAD_EN) byte 0x01 with parity bit 0 as operand B → error_paridad one-cycle pulse and FSM back to CARGA_A; inicio never asserted.
